// File: rtl/clk_enable_bank.sv
// Bank of NCH programmable clock-enable generators, each periodic or one-shot,
// reconfigured through a single-outstanding valid/ready port applied at channel wrap.
module clk_enable_bank #(
  parameter int WIDTH       = 8,
  parameter int NCH         = 2,
  parameter int DEFAULT_DIV = 255,
  localparam int CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic             cfg_mode,
  input  logic [NCH-1:0]   arm,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   busy
);

  localparam logic [CHW:0] NCH_X = (CHW+1)'(NCH);

  logic             r_ready;
  logic [CHW-1:0]   r_pch;
  logic [WIDTH-1:0] r_pdiv;
  logic             r_pmode;
  logic [NCH-1:0]   w_apply;
  logic             w_pch_bad;
  logic             w_take;

  assign w_pch_bad = ({1'b0, r_pch} >= NCH_X);
  assign w_take    = !r_ready && (w_pch_bad || (|w_apply));
  assign cfg_ready = r_ready;

  // r_ready low means a request is pending; it clears on the edge that consumes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready <= 1'b1;
    end else if (!r_ready) begin
      if (w_take) r_ready <= 1'b1;
    end else if (cfg_valid) begin
      r_ready <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_valid && r_ready) begin
      r_pch   <= cfg_ch;
      r_pdiv  <= cfg_div;
      r_pmode <= cfg_mode;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [CHW:0] IDX = (CHW+1)'(i);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div;
    logic             r_mode;
    logic             r_tick;
    logic             r_busy;
    logic             w_hit;
    logic             w_at_div;
    logic             w_wrap;
    logic             w_idle;
    logic             w_app;
    logic             w_nmode;

    assign w_hit    = !r_ready && ({1'b0, r_pch} == IDX);
    assign w_at_div = en && (r_cnt == r_div);
    // A retriggering arm on a busy one-shot suppresses that edge's wrap
    assign w_wrap   = w_at_div && (!r_mode || (r_busy && !arm[i]));
    assign w_idle   = r_mode && !r_busy;
    assign w_app    = w_hit && (clr || w_wrap || w_idle);
    assign w_nmode  = w_app ? r_pmode : r_mode;

    assign w_apply[i] = w_app;
    assign tick[i]    = r_tick;
    assign busy[i]    = r_busy;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt  <= '0;
        r_div  <= WIDTH'(DEFAULT_DIV);
        r_mode <= 1'b0;
        r_tick <= 1'b0;
        r_busy <= 1'b0;
      end else begin
        r_tick <= 1'b0;
        if (w_app) begin
          r_div  <= r_pdiv;
          r_mode <= r_pmode;
        end
        if (clr) begin
          r_cnt  <= '0;
          r_busy <= !w_nmode;
        end else if (w_wrap) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
          r_busy <= !w_nmode;
        end else if (!r_mode) begin
          r_busy <= 1'b1;
          if (en) r_cnt <= r_cnt + WIDTH'(1);
        end else if (!r_busy) begin
          r_cnt  <= '0;
          r_busy <= !w_nmode || arm[i];
        end else if (arm[i]) begin
          r_cnt <= '0;
        end else if (en) begin
          r_cnt <= r_cnt + WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_enable_bank.sv
// Directed bench for clk_enable_bank: default /256 rate, reconfiguration, one-shot,
// enable stall, clear, invalid channel and asynchronous reset.
module tb_clk_enable_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [0:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic       cfg_mode = 1'b0;
  logic [1:0] arm = '0;
  logic [1:0] tick;
  logic [1:0] busy;

  logic       en_b = 1'b0;
  logic       clr_b = 1'b0;
  logic       cfg_valid_b = 1'b0;
  logic       cfg_ready_b;
  logic [1:0] cfg_ch_b = '0;
  logic [3:0] cfg_div_b = '0;
  logic       cfg_mode_b = 1'b0;
  logic [2:0] arm_b = '0;
  logic [2:0] tick_b;
  logic [2:0] busy_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_enable_bank #(.WIDTH(8), .NCH(2), .DEFAULT_DIV(255)) u_dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .arm(arm), .tick(tick), .busy(busy)
  );

  clk_enable_bank #(.WIDTH(4), .NCH(3), .DEFAULT_DIV(5)) u_b (
    .clk(clk), .rst(rst), .en(en_b), .clr(clr_b),
    .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b), .cfg_ch(cfg_ch_b),
    .cfg_div(cfg_div_b), .cfg_mode(cfg_mode_b), .arm(arm_b), .tick(tick_b), .busy(busy_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++;
    if ({tick, busy, cfg_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_state got=%b want=00001", {tick, busy, cfg_ready});
    end
    rst = 1'b0;
    en  = 1'b1;
  endtask

  task automatic test_div256();
    logic [1:0] exp;
    for (int c = 1; c <= 512; c++) begin
      step();
      exp = (c == 256 || c == 512) ? 2'b11 : 2'b00;
      checks++;
      if (tick !== exp) begin
        errors++;
        $display("FAIL div256 edge=%0d got=%b want=%b", c, tick, exp);
      end
    end
    checks++;
    if (busy !== 2'b11) begin
      errors++;
      $display("FAIL periodic_busy got=%b want=11", busy);
    end
  endtask

  task automatic test_cfg_apply();
    repeat (100) step();
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd3; cfg_mode = 1'b0;
    step();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL cfg_ready_drop got=%b want=0", cfg_ready);
    end
    for (int c = 1; c <= 154; c++) begin
      step();
      checks++;
      if ({tick, cfg_ready} !== 3'b000) begin
        errors++;
        $display("FAIL cfg_old_period edge=%0d got=%b want=000", c, {tick, cfg_ready});
      end
    end
    step();
    checks++;
    if ({tick, cfg_ready} !== 3'b111) begin
      errors++;
      $display("FAIL cfg_apply_edge got=%b want=111", {tick, cfg_ready});
    end
    for (int c = 1; c <= 8; c++) begin
      step();
      checks++;
      if (tick[0] !== (c % 4 == 0)) begin
        errors++;
        $display("FAIL cfg_div4 edge=%0d got=%b want=%b", c, tick[0], (c % 4 == 0));
      end
    end
  endtask

  task automatic test_oneshot();
    int n;
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd9; cfg_mode = 1'b1;
    step();
    cfg_valid = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!cfg_ready && n < 300);
    checks++;
    if (n !== 247 || tick[1] !== 1'b1 || busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_apply edges=%0d tick1=%b busy1=%b want 247/1/0", n, tick[1], busy[1]);
    end
    arm = 2'b10;
    step();
    arm = 2'b00;
    checks++;
    if ({tick[1], busy[1]} !== 2'b01) begin
      errors++;
      $display("FAIL arm_edge got=%b want=01", {tick[1], busy[1]});
    end
    for (int c = 1; c <= 12; c++) begin
      step();
      checks++;
      if ({tick[1], busy[1]} !== {c == 10, c < 10}) begin
        errors++;
        $display("FAIL oneshot edge=%0d got=%b want=%b", c, {tick[1], busy[1]}, {c == 10, c < 10});
      end
    end
    arm = 2'b10;
    step();
    arm = 2'b00;
    repeat (4) step();
    arm = 2'b10;
    step();
    arm = 2'b00;
    checks++;
    if ({tick[1], busy[1]} !== 2'b01) begin
      errors++;
      $display("FAIL retrigger_edge got=%b want=01", {tick[1], busy[1]});
    end
    for (int c = 1; c <= 10; c++) begin
      step();
      checks++;
      if ({tick[1], busy[1]} !== {c == 10, c < 10}) begin
        errors++;
        $display("FAIL retrigger edge=%0d got=%b want=%b", c, {tick[1], busy[1]}, {c == 10, c < 10});
      end
    end
  endtask

  task automatic test_en_stall();
    int n;
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd4; cfg_mode = 1'b0;
    step();
    cfg_valid = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!cfg_ready && n < 10);
    checks++;
    if (cfg_ready !== 1'b1 || tick[0] !== 1'b1) begin
      errors++;
      $display("FAIL div4_apply ready=%b tick0=%b want 1/1", cfg_ready, tick[0]);
    end
    repeat (2) step();
    en = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      step();
      checks++;
      if (tick[0] !== 1'b0) begin
        errors++;
        $display("FAIL en_low edge=%0d got=%b want=0", c, tick[0]);
      end
    end
    en = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++;
      if (tick[0] !== (c == 3)) begin
        errors++;
        $display("FAIL en_resume edge=%0d got=%b want=%b", c, tick[0], (c == 3));
      end
    end
  endtask

  task automatic test_clr();
    logic [3:0] exp;
    arm = 2'b10;
    step();
    arm = 2'b00;
    repeat (3) step();
    clr = 1'b1;
    arm = 2'b10;
    step();
    clr = 1'b0;
    arm = 2'b00;
    checks++;
    if ({tick, busy} !== 4'b0001) begin
      errors++;
      $display("FAIL clr_edge got=%b want=0001", {tick, busy});
    end
    for (int c = 1; c <= 12; c++) begin
      step();
      exp = (c == 5 || c == 10) ? 4'b0101 : 4'b0001;
      checks++;
      if ({tick, busy} !== exp) begin
        errors++;
        $display("FAIL after_clr edge=%0d got=%b want=%b", c, {tick, busy}, exp);
      end
    end
  endtask

  task automatic test_badch();
    logic [2:0] exp;
    logic [2:0] tbl [6];
    tbl = '{3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b111};
    en_b = 1'b1;
    cfg_valid_b = 1'b1; cfg_ch_b = 2'd3; cfg_div_b = 4'd1; cfg_mode_b = 1'b0;
    step();
    cfg_valid_b = 1'b0;
    checks++;
    if (cfg_ready_b !== 1'b0) begin
      errors++;
      $display("FAIL badch_accept got=%b want=0", cfg_ready_b);
    end
    step();
    checks++;
    if (cfg_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL badch_discard got=%b want=1", cfg_ready_b);
    end
    for (int c = 3; c <= 12; c++) begin
      step();
      exp = (c == 6 || c == 12) ? 3'b111 : 3'b000;
      checks++;
      if (tick_b !== exp) begin
        errors++;
        $display("FAIL badch_ticks edge=%0d got=%b want=%b", c, tick_b, exp);
      end
    end
    cfg_valid_b = 1'b1; cfg_ch_b = 2'd1; cfg_div_b = 4'd1; cfg_mode_b = 1'b0;
    step();
    cfg_valid_b = 1'b0;
    clr_b = 1'b1;
    step();
    clr_b = 1'b0;
    checks++;
    if ({tick_b, cfg_ready_b} !== 4'b0001) begin
      errors++;
      $display("FAIL clr_apply got=%b want=0001", {tick_b, cfg_ready_b});
    end
    for (int c = 1; c <= 6; c++) begin
      step();
      checks++;
      if (tick_b !== tbl[c-1]) begin
        errors++;
        $display("FAIL clr_applied_div edge=%0d got=%b want=%b", c, tick_b, tbl[c-1]);
      end
    end
  endtask

  task automatic test_rst();
    logic [1:0] exp;
    arm = 2'b10;
    step();
    arm = 2'b00;
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd2; cfg_mode = 1'b0;
    step();
    cfg_valid = 1'b0;
    checks++;
    if ({busy, cfg_ready} !== 3'b110) begin
      errors++;
      $display("FAIL pre_rst got=%b want=110", {busy, cfg_ready});
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({tick, busy, cfg_ready, cfg_ready_b} !== 6'b000011) begin
      errors++;
      $display("FAIL async_rst got=%b want=000011", {tick, busy, cfg_ready, cfg_ready_b});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b1;
    for (int c = 1; c <= 256; c++) begin
      step();
      exp = (c == 256) ? 2'b11 : 2'b00;
      checks++;
      if (tick !== exp) begin
        errors++;
        $display("FAIL post_rst edge=%0d got=%b want=%b", c, tick, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_div256();
    test_cfg_apply();
    test_oneshot();
    test_en_stall();
    test_clr();
    test_badch();
    test_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
